canny_frame_seq: RTL and testbench
==================================

Name: canny_frame_seq

Overview:
- Frame-level sequencer for the two-pass Canny back end; sits between the gradient/NMS datapath and the single-port 1-bit NMS edge RAM.
- Pass 1 (FILL): generates RAM write addresses with pipeline-delay compensation while building the 64-bin magnitude histogram.
- THRESH: scans the histogram to derive the hysteresis thresholds thH/thL.
- Pass 2 (HYST): generates RAM read addresses and edge-output addresses, then pulses done.
- Replaces ad-hoc free-running counters and dual-clock RAM muxing with one clock and an explicit start/done handshake.

Parameters:
- IMG_W, 512, image width in pixels.
- IMG_H, 505, image height in lines; N = IMG_W*IMG_H, must be below 2^18.
- W_DLY, 514, beats between pixel entry and the matching NMS result (write-address offset).
- R_DLY, 517, cycles between RAM read address and the matching hysteresis edge output.
- HIST_BINS, 64, number of histogram bins; mag values ≥ HIST_BINS are not counted.
- HI_NUM, 4, numerator of the high-threshold cumulative fraction.
- HI_DEN, 5, denominator of that fraction.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start request.
- pix_valid  in  1  upstream pixel/NMS beat valid during FILL.
- mag  in  8  gradient magnitude of the current pixel.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of HYST.
- phase  out  2  0=IDLE, 1=FILL, 2=THRESH, 3=HYST.
- ram_we  out  1  NMS RAM write enable.
- ram_addr  out  18  NMS RAM address (write in FILL, read in HYST).
- th_h  out  8  high threshold.
- th_l  out  8  low threshold, equal to th_h>>1.
- th_valid  out  1  thresholds valid.
- edge_valid  out  1  hysteresis output beat valid.
- edge_addr  out  18  pixel address of the current hysteresis output.

Behaviour:
- Reset (async, rst=0): all outputs 0; state IDLE; counters, accumulator and all histogram bins 0. Reset mid-frame aborts immediately; no done pulse is produced.
- IDLE:
  - start=1 → clear histogram, th_valid=0, pix_cnt=0, go to FILL. busy rises next cycle.
  - start while busy is ignored.
- FILL:
  - pix_cnt advances only on pix_valid; a pix_valid gap holds every output and counter.
  - Histogram: hist[mag]++ when pix_valid && pix_cnt<N && mag<HIST_BINS. Bins are 18-bit and saturate at 2^18-1.
  - Write side: ram_we = pix_valid && pix_cnt≥W_DLY; ram_addr = pix_cnt−W_DLY (combinational from registered pix_cnt).
  - Upstream supplies N+W_DLY valid beats (the tail flushes the pipeline). On the beat where pix_cnt==N+W_DLY−1 → THRESH.
- THRESH:
  - Scans one bin per cycle, bin=0..HIST_BINS−1, with acc_next = acc + hist[bin].
  - If acc_next*HI_DEN ≥ N*HI_NUM (constant multiplies, 24-bit compare, no divider): th_h=bin, th_l=bin>>1, th_valid=1, go to HYST.
  - If the last bin is reached without a hit: th_h=HIST_BINS−1, th_l=(HIST_BINS−1)>>1, th_valid=1, go to HYST.
  - Latency is 1..HIST_BINS cycles; ram_we=0 throughout.
- HYST:
  - rd_cnt runs 0..N+R_DLY−1, one per cycle, with no stall.
  - ram_addr = rd_cnt while rd_cnt<N, else held at N−1; ram_we=0.
  - edge_valid = rd_cnt≥R_DLY; edge_addr = rd_cnt−R_DLY.
  - At rd_cnt==N+R_DLY−1: done=1 for one cycle, busy=0, go to IDLE.
- th_h, th_l and th_valid hold their values after done until the next accepted start.
- Every state transition takes effect on the clock edge after its condition holds; no state is skipped.

Optional Feature:
- Macro CANNY_TH_OVERRIDE_EN.
- Defined: adds ports th_ovr (in, 1), th_h_ovr (in, 8), th_l_ovr (in, 8), all sampled at start. If th_ovr=1, FILL→HYST directly: THRESH is skipped, th_h/th_l are loaded from the override ports, th_valid=1. The histogram is still built.
- Undefined: ports absent; THRESH always runs.

Test Plan (IMG_W=8, IMG_H=4, N=32, W_DLY=3, R_DLY=4, HI 4/5, HIST_BINS=64):
- Reset: hold rst=0 with random inputs → every output 0, phase=0. Release and idle 10 cycles → outputs unchanged.
- Uniform frame: start, then 35 valid beats with mag=10 → ram_we first high on beat 4 (addr 0), last write addr 31. th_h=10, th_l=5, th_valid rises 11 cycles after FILL ends. done fires 36 cycles after HYST entry; edge_addr runs 0..31.
- Bimodal frame: 16 beats mag=2 and 16 beats mag=20, plus 3 flush beats → th_h=20, th_l=10 (acc 16 at bin 2 is below the 25.6 target; 32 at bin 20 meets it).
- Stall: insert 5-cycle pix_valid gaps every 4 beats → same ram_addr sequence and thresholds as the uniform case; ram_we low during the gaps.
- Out of range: all mag=200 → th_h=63, th_l=31 after exactly 64 THRESH cycles.
- Control: start pulsed during HYST → ignored, exactly one done. rst asserted mid-HYST → IDLE, no done, th_valid=0.

Source files
------------

// File: rtl/canny_frame_seq.sv
// Frame sequencer for the two-pass Canny back end: FILL (write + histogram), THRESH, HYST (read + edge output).
// Optional macro CANNY_TH_OVERRIDE_EN adds start-sampled threshold override ports that skip THRESH.
module canny_frame_seq #(
  parameter int IMG_W     = 512,
  parameter int IMG_H     = 505,
  parameter int W_DLY     = 514,
  parameter int R_DLY     = 517,
  parameter int HIST_BINS = 64,
  parameter int HI_NUM    = 4,
  parameter int HI_DEN    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [7:0]  mag,
`ifdef CANNY_TH_OVERRIDE_EN
  input  logic        th_ovr,
  input  logic [7:0]  th_h_ovr,
  input  logic [7:0]  th_l_ovr,
`endif
  output logic        busy,
  output logic        done,
  output logic [1:0]  phase,
  output logic        ram_we,
  output logic [17:0] ram_addr,
  output logic [7:0]  th_h,
  output logic [7:0]  th_l,
  output logic        th_valid,
  output logic        edge_valid,
  output logic [17:0] edge_addr
);

  localparam int          N         = IMG_W * IMG_H;
  localparam int          BW        = $clog2(HIST_BINS);
  localparam logic [18:0] N_CNT     = 19'(N);
  localparam logic [18:0] W_OFF     = 19'(W_DLY);
  localparam logic [18:0] R_OFF     = 19'(R_DLY);
  localparam logic [18:0] FILL_LAST = 19'(N + W_DLY - 1);
  localparam logic [18:0] HYST_LAST = 19'(N + R_DLY - 1);
  localparam logic [23:0] TARGET    = 24'(N * HI_NUM);
  localparam logic [23:0] DEN       = 24'(HI_DEN);
  localparam logic [BW-1:0] LAST_BIN = BW'(HIST_BINS - 1);
  localparam logic [7:0]  TH_MAX    = 8'(HIST_BINS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_THRESH = 2'd2,
    ST_HYST   = 2'd3
  } state_t;

  function automatic logic [17:0] sat_inc(input logic [17:0] v);
    if (&v) return v;
    else    return v + 18'd1;
  endfunction

  state_t          state_r, state_s;
  logic [18:0]     pix_cnt_r, rd_cnt_r;
  logic [BW-1:0]   bin_r;
  logic [23:0]     acc_r;
  logic [17:0]     hist_r [HIST_BINS];
  logic [7:0]      th_h_r, th_l_r;
  logic            th_valid_r, done_r;
  logic            ram_we_s, edge_valid_s;
  logic [17:0]     ram_addr_s, edge_addr_s;
  logic [18:0]     fill_diff_s, hyst_diff_s;
  logic [23:0]     acc_next_s, scaled_s;
  logic [7:0]      bin_ext_s;
  logic            fill_last_s, hyst_last_s, hit_s, scan_end_s, mag_in_range_s;
  logic            skip_thresh_s;
`ifdef CANNY_TH_OVERRIDE_EN
  logic            ovr_r;
  logic [7:0]      th_h_ovr_r, th_l_ovr_r;
  assign skip_thresh_s = ovr_r;
`else
  assign skip_thresh_s = 1'b0;
`endif

  assign fill_diff_s    = pix_cnt_r - W_OFF;
  assign hyst_diff_s    = rd_cnt_r - R_OFF;
  assign fill_last_s    = (state_r == ST_FILL) && pix_valid && (pix_cnt_r == FILL_LAST);
  assign hyst_last_s    = (state_r == ST_HYST) && (rd_cnt_r == HYST_LAST);
  assign mag_in_range_s = ({1'b0, mag} < 9'(HIST_BINS));
  assign acc_next_s     = acc_r + 24'(hist_r[bin_r]);
  // Constant multiply replaces a divide: acc/N >= HI_NUM/HI_DEN.
  assign scaled_s       = acc_next_s * DEN;
  assign hit_s          = (scaled_s >= TARGET);
  assign scan_end_s     = hit_s || (bin_r == LAST_BIN);
  assign bin_ext_s      = 8'(bin_r);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Next-state and per-phase RAM/edge outputs
  always_comb begin
    state_s      = state_r;
    ram_we_s     = 1'b0;
    ram_addr_s   = 18'd0;
    edge_valid_s = 1'b0;
    edge_addr_s  = 18'd0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_FILL;
        else       state_s = ST_IDLE;
      end
      ST_FILL: begin
        ram_we_s   = pix_valid && (pix_cnt_r >= W_OFF);
        ram_addr_s = fill_diff_s[17:0];
        if (fill_last_s) state_s = skip_thresh_s ? ST_HYST : ST_THRESH;
        else             state_s = ST_FILL;
      end
      ST_THRESH: begin
        if (scan_end_s) state_s = ST_HYST;
        else            state_s = ST_THRESH;
      end
      ST_HYST: begin
        ram_addr_s   = (rd_cnt_r < N_CNT) ? rd_cnt_r[17:0] : 18'(N - 1);
        edge_valid_s = (rd_cnt_r >= R_OFF);
        edge_addr_s  = hyst_diff_s[17:0];
        if (hyst_last_s) state_s = ST_IDLE;
        else             state_s = ST_HYST;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Counters, histogram, threshold scan and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_r  <= 19'd0;
      rd_cnt_r   <= 19'd0;
      bin_r      <= '0;
      acc_r      <= 24'd0;
      th_h_r     <= 8'd0;
      th_l_r     <= 8'd0;
      th_valid_r <= 1'b0;
      done_r     <= 1'b0;
      for (int i = 0; i < HIST_BINS; i++) hist_r[i] <= 18'd0;
`ifdef CANNY_TH_OVERRIDE_EN
      ovr_r      <= 1'b0;
      th_h_ovr_r <= 8'd0;
      th_l_ovr_r <= 8'd0;
`endif
    end else begin
      done_r <= hyst_last_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            pix_cnt_r  <= 19'd0;
            th_valid_r <= 1'b0;
            for (int i = 0; i < HIST_BINS; i++) hist_r[i] <= 18'd0;
`ifdef CANNY_TH_OVERRIDE_EN
            ovr_r      <= th_ovr;
            th_h_ovr_r <= th_h_ovr;
            th_l_ovr_r <= th_l_ovr;
`endif
          end
        end
        ST_FILL: begin
          if (pix_valid) begin
            pix_cnt_r <= pix_cnt_r + 19'd1;
            if ((pix_cnt_r < N_CNT) && mag_in_range_s)
              hist_r[mag[BW-1:0]] <= sat_inc(hist_r[mag[BW-1:0]]);
          end
          if (fill_last_s) begin
            bin_r    <= '0;
            acc_r    <= 24'd0;
            rd_cnt_r <= 19'd0;
`ifdef CANNY_TH_OVERRIDE_EN
            if (ovr_r) begin
              th_h_r     <= th_h_ovr_r;
              th_l_r     <= th_l_ovr_r;
              th_valid_r <= 1'b1;
            end
`endif
          end
        end
        ST_THRESH: begin
          if (hit_s) begin
            th_h_r     <= bin_ext_s;
            th_l_r     <= {1'b0, bin_ext_s[7:1]};
            th_valid_r <= 1'b1;
          end else if (bin_r == LAST_BIN) begin
            th_h_r     <= TH_MAX;
            th_l_r     <= {1'b0, TH_MAX[7:1]};
            th_valid_r <= 1'b1;
          end else begin
            bin_r <= bin_r + {{(BW-1){1'b0}}, 1'b1};
            acc_r <= acc_next_s;
          end
        end
        ST_HYST: rd_cnt_r <= rd_cnt_r + 19'd1;
        default: ;
      endcase
    end
  end

  assign busy       = (state_r != ST_IDLE);
  assign phase      = state_r;
  assign done       = done_r;
  assign ram_we     = ram_we_s;
  assign ram_addr   = ram_addr_s;
  assign th_h       = th_h_r;
  assign th_l       = th_l_r;
  assign th_valid   = th_valid_r;
  assign edge_valid = edge_valid_s;
  assign edge_addr  = edge_addr_s;

endmodule

// File: tb/tb_canny_frame_seq.sv
// Directed self-checking bench for canny_frame_seq with an 8x4 image, W_DLY=3, R_DLY=4.
module tb_canny_frame_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  mag = 8'd0;
  logic        busy, done, ram_we, th_valid, edge_valid;
  logic [1:0]  phase;
  logic [17:0] ram_addr, edge_addr;
  logic [7:0]  th_h, th_l;

  int n_cmp = 0;
  int n_mis = 0;

  canny_frame_seq #(
    .IMG_W(8), .IMG_H(4), .W_DLY(3), .R_DLY(4),
    .HIST_BINS(64), .HI_NUM(4), .HI_DEN(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .mag(mag),
    .busy(busy), .done(done), .phase(phase), .ram_we(ram_we), .ram_addr(ram_addr),
    .th_h(th_h), .th_l(th_l), .th_valid(th_valid),
    .edge_valid(edge_valid), .edge_addr(edge_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {5'd0, busy, done, phase, ram_we, ram_addr, th_h, th_l, th_valid, edge_valid, edge_addr};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1; #1;
    @(negedge clk); start = 1'b0; #1;
    chk("start_busy", busy, 1);
    chk("start_phase", phase, 1);
    chk("start_thv_clr", th_valid, 0);
  endtask

  // 35 beats; mag m0 for beats 1..split, m1 afterwards; optional 5-cycle gap after every 4th beat
  task automatic fill(input logic [7:0] m0, input logic [7:0] m1, input int split, input bit stall);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      mag = (k <= split) ? m0 : m1;
      #1;
      chk("fill_we", ram_we, (k >= 4) ? 1 : 0);
      if (k >= 4) chk("fill_addr", ram_addr, k - 4);
      if (stall && (k % 4 == 0) && (k < 35)) begin
        for (int g = 0; g < 5; g++) begin
          @(negedge clk);
          pix_valid = 1'b0;
          mag = 8'd99;
          #1;
          chk("gap_we", ram_we, 0);
          chk("gap_addr", ram_addr, k - 3);
          chk("gap_phase", phase, 1);
        end
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    mag = 8'd0;
    #1;
    chk("thr_phase", phase, 2);
    chk("thr_we", ram_we, 0);
    chk("thr_thv", th_valid, 0);
  endtask

  // Count cycles from end of FILL until th_valid, bounded
  task automatic wait_thresh(input int exp_cyc, input int exp_h, input int exp_l);
    int cyc;
    cyc = 0;
    while (cyc <= 100) begin
      if (th_valid) break;
      step();
      cyc++;
    end
    chk("thr_cycles", cyc, exp_cyc);
    chk("thr_th_h", th_h, exp_h);
    chk("thr_th_l", th_l, exp_l);
    chk("thr_to_hyst", phase, 3);
  endtask

  task automatic run_hyst(input bit poke_start, input int exp_h);
    for (int j = 0; j <= 35; j++) begin
      chk("hyst_addr", ram_addr, (j < 32) ? j : 31);
      chk("hyst_we", ram_we, 0);
      chk("hyst_ev", edge_valid, (j >= 4) ? 1 : 0);
      if (j >= 4) chk("hyst_eaddr", edge_addr, j - 4);
      chk("hyst_done_lo", done, 0);
      chk("hyst_busy", busy, 1);
      @(negedge clk);
      start = (poke_start && (j == 10)) ? 1'b1 : 1'b0;
      #1;
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_phase", phase, 0);
    step();
    chk("done_once", done, 0);
    chk("idle_after", phase, 0);
    chk("th_hold", th_h, exp_h);
    chk("thv_hold", th_valid, 1);
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      pix_valid = 1'($urandom_range(0, 1));
      mag = 8'($urandom_range(0, 255));
      #1;
      chk("reset_outs", all_out(), 64'd0);
    end
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b0; mag = 8'd0;
    rst = 1'b1;
    repeat (10) step();
    chk("idle_outs", all_out(), 64'd0);

    // Uniform frame
    do_start();
    fill(8'd10, 8'd10, 35, 1'b0);
    wait_thresh(11, 10, 5);
    run_hyst(1'b0, 10);

    // Bimodal frame
    do_start();
    fill(8'd2, 8'd20, 16, 1'b0);
    wait_thresh(21, 20, 10);
    run_hyst(1'b0, 20);

    // Stalled uniform frame
    do_start();
    fill(8'd10, 8'd10, 35, 1'b1);
    wait_thresh(11, 10, 5);
    run_hyst(1'b0, 10);

    // Out-of-range magnitudes
    do_start();
    fill(8'd200, 8'd200, 35, 1'b0);
    wait_thresh(64, 63, 31);
    run_hyst(1'b0, 63);

    // Start during HYST is ignored
    do_start();
    fill(8'd10, 8'd10, 35, 1'b0);
    wait_thresh(11, 10, 5);
    run_hyst(1'b1, 10);
    repeat (5) step();
    chk("no_restart", phase, 0);

    // Reset in the middle of HYST
    do_start();
    fill(8'd2, 8'd20, 16, 1'b0);
    wait_thresh(21, 20, 10);
    repeat (10) step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_outs", all_out(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (done) dones++;
      end
      chk("midrst_no_done", dones, 0);
    end
    chk("midrst_phase", phase, 0);
    chk("midrst_thv", th_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
